// File: rtl/demux_pkg.sv
// Shared constants, mode encodings and FSM state type for the 1-to-8 bit demultiplexer.
package demux_pkg;

    localparam int DEMUX_W     = 8;
    localparam int DEMUX_SEL_W = 3;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

    typedef enum logic {
        IDLE,
        COLLECT
    } demux_state_e;

endpackage

// File: rtl/demux1to8_reg_if.sv
// Bit-serial write port and byte-wide result port of demux1to8_reg.
interface demux1to8_reg_if;
    import demux_pkg::*;

    logic                   in_valid;
    logic                   in_bit;
    logic [DEMUX_SEL_W-1:0] sel;
    logic                   mode;
    logic                   clear;
    logic [DEMUX_W-1:0]     dout;
    logic                   word_valid;
    logic                   busy;
    logic [DEMUX_SEL_W-1:0] idx;

    modport master (
        output in_valid, in_bit, sel, mode, clear,
        input  dout, word_valid, busy, idx
    );

    modport slave (
        input  in_valid, in_bit, sel, mode, clear,
        output dout, word_valid, busy, idx
    );

endinterface

// File: rtl/decoder3to8.sv
// 3-bit index to one-hot 8-bit write enable.
module decoder3to8
    import demux_pkg::*;
(
    input  logic [DEMUX_SEL_W-1:0] index,
    output logic [DEMUX_W-1:0]     onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < DEMUX_W; gi++) begin : g_dec
            assign onehot[gi] = (index == DEMUX_SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/demux1to8_reg.sv
// Registered 1-to-8 bit demultiplexer: addressed bit writes into dout, or LSB-first
// byte reassembly with a one-cycle word_valid pulse at frame completion.
module demux1to8_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_W
) (
    input  logic             clk,
    input  logic             reset,
    demux1to8_reg_if.slave   bus
);

    demux_state_e            state_reg, state_next;
    logic [DEMUX_SEL_W-1:0]  idx_reg, idx_next;
    logic [WIDTH-1:0]        asm_reg, asm_next;
    logic [WIDTH-1:0]        dout_reg, dout_next;
    logic                    word_valid_reg, word_valid_next;

    logic [DEMUX_SEL_W-1:0]  dec_index;
    logic [DEMUX_W-1:0]      write_en;
    logic                    accept;
    logic                    mode_abort;

    // One decoder serves both modes; the index source follows the current mode.
    assign dec_index = (bus.mode == MODE_SEQ) ? idx_reg : bus.sel;

    decoder3to8 u_decoder (
        .index  (dec_index),
        .onehot (write_en)
    );

    // An explicit clear drops the bit; a mode switch mid-frame only aborts the frame.
    assign accept     = bus.in_valid & ~bus.clear;
    assign mode_abort = (state_reg == COLLECT) && (bus.mode == MODE_ADDR);

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        asm_next        = asm_reg;
        dout_next       = dout_reg;
        word_valid_next = 1'b0;

        if (bus.clear || mode_abort) begin
            state_next = IDLE;
            idx_next   = '0;
        end

        if (accept) begin
            if (bus.mode == MODE_ADDR) begin
                dout_next       = (dout_reg & ~write_en) | (write_en & {WIDTH{bus.in_bit}});
                word_valid_next = 1'b1;
            end else begin
                asm_next = (asm_reg & ~write_en) | (write_en & {WIDTH{bus.in_bit}});
                idx_next = idx_reg + DEMUX_SEL_W'(1);
                if (idx_reg == DEMUX_SEL_W'(WIDTH - 1)) begin
                    // Last bit bypasses asm so the word is published on this same edge.
                    dout_next       = {bus.in_bit, asm_reg[WIDTH-2:0]};
                    word_valid_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    state_next = COLLECT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            asm_reg        <= '0;
            dout_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            asm_reg        <= asm_next;
            dout_reg       <= dout_next;
            word_valid_reg <= word_valid_next;
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.word_valid = word_valid_reg;
    assign bus.busy       = (state_reg == COLLECT);
    assign bus.idx        = idx_reg;

endmodule

// File: doc/demux1to8_reg.md
# demux1to8_reg

- Registered 1-to-8 bit demultiplexer: the write-side counterpart of the 8:1 bit mux.
- Steers a serial input bit into one of eight output bit positions, either at an explicit 3-bit select or at an internal auto-incrementing index.
- In sequential mode it reassembles a byte from a serialized bit stream and presents it as a stable word with a one-cycle valid pulse.
- Sits between a bit-serial source (mux-based serializer, control/status sequencer) and byte-wide datapath logic.

## Interface
Parameters:
- `WIDTH`, 8: output word width; the select width is fixed at 3, so only 8 is supported.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock domain, no async reset.
- `in_valid`  in  1  `in_bit` is accepted on this edge.
- `in_bit`  in  1  data bit to steer.
- `sel`  in  3  target bit index `{S2,S1,S0}`, with `sel[0]` the LSB; used in addressed mode only.
- `mode`  in  1  0 = addressed, 1 = sequential.
- `clear`  in  1  synchronous abort of a partial sequential frame.
- `dout`  out  8  presented word; bit i corresponds to mux input `Bi`.
- `word_valid`  out  1  one-cycle pulse: `dout` was updated on the preceding edge.
- `busy`  out  1  a sequential frame is partially collected (index != 0).
- `idx`  out  3  next bit position in sequential mode.

## Operation
- Internal state: assembly register `asm[7:0]`, index `idx[2:0]`, FSM state `IDLE` / `COLLECT`.
- Addressed mode (`mode`=0), on `in_valid`:
  - `dout[sel] <= in_bit`; all other `dout` bits hold.
  - `word_valid` pulses; `asm`, `idx` and FSM are untouched.
- Sequential mode (`mode`=1), on `in_valid`:
  - `asm[idx] <= in_bit`; `idx <= idx+1`, wrapping 7 -> 0.
  - `IDLE` -> `COLLECT` on the first accepted bit.
  - On the bit with `idx`=7: `dout <= {in_bit, asm[6:0]}`, `word_valid` pulses, FSM returns to `IDLE`, `idx` wraps to 0.
  - Bits are LSB-first: the first accepted bit lands in `dout[0]`.
- `dout` changes only at frame completion, so it stays stable while the next frame collects.
- `clear`: `idx <= 0`, FSM -> `IDLE`, `asm` contents become don't-care; `dout` is not changed.
  - `clear` together with `in_valid`: clear wins and the bit is dropped.
- Change of `mode` while `busy`: treated as an implicit clear on that edge; a bit presented on that edge is processed under the new mode.
- `in_valid`=0: no state change and no pulse.
- `busy` = (FSM == `COLLECT`).

## Timing
- Reset values: `dout`=8'h00, `word_valid`=0, `busy`=0, `idx`=0, `asm`=8'h00, FSM=`IDLE`.
- Reset mid-frame discards the partial frame; reset has priority over every other input.
- Latency: `dout` and `word_valid` are registered, visible one cycle after the accepting edge.
- Throughput: one bit per cycle. Back-to-back frames need no gap: the 8th bit of frame N and the 1st bit of frame N+1 are on consecutive edges.
- With `in_valid` held high in sequential mode, `word_valid` pulses exactly every 8 cycles.
- No backpressure: the block is always ready.
- `word_valid` never stays high for two cycles unless two qualifying writes occur on consecutive edges (addressed mode).

## Structure
- Shared package `demux_pkg`:
  - `DEMUX_W`=8, `DEMUX_SEL_W`=3.
  - Mode encodings `MODE_ADDR`=1'b0, `MODE_SEQ`=1'b1.
  - FSM state typedef {`IDLE`, `COLLECT`}.
- Sub-module `decoder3to8`: 3-bit index to one-hot 8-bit write enable.
  - Instantiated once; its input is muxed between `sel` (addressed) and `idx` (sequential), and the one-hot output gates the writes into `dout` or `asm`.

## Test plan
- Reset, then sequential mode, bits 0,1,0,1,0,1,0,1 on consecutive cycles -> `dout`=8'hAA with a single `word_valid` pulse one cycle after the 8th bit; `busy` high for cycles 1-7.
- Addressed mode from reset: write 1 at `sel`=5, then 1 at `sel`=0 -> `dout`=8'h20 then 8'h21, one `word_valid` pulse per write.
- Sequential: 3 bits, then `clear`, then 1,0,0,1,1,0,0,1 -> `dout`=8'h99, with no `word_valid` before the 8th post-clear bit.
- Continuous stream: 0xAA then 0x99 with `in_valid` never deasserted -> `word_valid` pulses 8 cycles apart, `dout` shows 8'hAA then 8'h99, `idx` wraps 7 -> 0.
- `reset` asserted after 5 sequential bits -> all outputs 0 next cycle; the following 8 bits of all 1s give `dout`=8'hFF.
- Toggle `mode` to addressed after 4 sequential bits with an addressed write of 1 at `sel`=7 on that edge -> `idx`=0, `busy`=0, `dout`=8'h80.
